// File: rtl/hcsr04_emulator.sv
// hcsr04_emulator
//   Responder side of the HC-SR04 ranging protocol. Watches the trig pulse
//   from the sensor-interface logic and answers with an echo pulse whose width
//   encodes a programmed target distance. This lets a bench or a switch bank
//   stand in for a real sensor with an object at a chosen range.
//
//   Sequence: IDLE -> TRIG (trig high) -> BURST -> ECHO (echo high) -> HOLDOFF
//   -> IDLE. Every state duration is an exact multiple of CLK_PER_US clocks.
//
// Ports
//   clk          system clock (CLK_PER_US cycles per microsecond)
//   reset        asynchronous, active-high reset
//   trig         trigger from the initiator, asynchronous to clk
//   echo_us      desired echo width in us, sampled on an accepted trig fall
//   target_valid 1 = object present, 0 = no object (maximum echo width)
//   echo         echo pulse, registered
//   busy         high from BURST entry to the end of HOLDOFF
//   trig_err     one-cycle pulse on a rejected runt trig
//
// Configuration
//   HCSR04_EMU_TRIG_CHECK_EN  when defined, trig pulses shorter than
//                             MIN_TRIG_US are rejected and flagged on
//                             trig_err. When undefined, any synchronized pulse
//                             is accepted and trig_err is constant 0.
module hcsr04_emulator #(
  parameter int CLK_PER_US     = 40,
  parameter int MIN_TRIG_US    = 10,
  parameter int BURST_DELAY_US = 460,
  parameter int NO_ECHO_US     = 38000,
  parameter int HOLDOFF_US     = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic [15:0] echo_us,
  input  logic        target_valid,
  output logic        echo,
  output logic        busy,
  output logic        trig_err
);

`ifdef HCSR04_EMU_TRIG_CHECK_EN
  localparam bit TRIG_CHECK = 1'b1;
`else
  localparam bit TRIG_CHECK = 1'b0;
`endif

  // With the check disabled the threshold is one cycle, which every pulse that
  // reaches TRIG already satisfies.
  localparam int MIN_CYC = TRIG_CHECK ? MIN_TRIG_US * CLK_PER_US : 1;
  localparam int WW      = $clog2(MIN_CYC + 1);
  localparam int PW      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [WW-1:0] MIN_W      = WW'(MIN_CYC);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_US - 1);
  localparam logic [15:0]   BURST_LAST = 16'(BURST_DELAY_US - 1);
  localparam logic [15:0]   HOLD_LAST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]   NO_ECHO    = 16'(NO_ECHO_US);

  typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;

  state_t        state, nstate;
  logic          trig_m, trig_s, trig_d;
  logic [WW-1:0] wcnt;
  logic [PW-1:0] pre;
  logic [15:0]   ucnt;
  logic [15:0]   w_us;
  logic          trig_rise, us_tick, runt;
  logic          echo_d, busy_d;

  assign trig_rise = trig_s & ~trig_d;
  assign us_tick   = (pre == PRE_LAST);

  // State register, synchronizer, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      trig_d   <= 1'b0;
      state    <= IDLE;
      wcnt     <= '0;
      pre      <= '0;
      ucnt     <= '0;
      w_us     <= '0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      trig_d   <= trig_s;
      state    <= nstate;
      echo     <= echo_d;
      busy     <= busy_d;
      trig_err <= TRIG_CHECK && runt;

      if (state == IDLE && trig_rise)
        wcnt <= WW'(1);
      else if (state == TRIG && trig_s && wcnt != '1)
        wcnt <= wcnt + 1'b1;

      // Restart the us timebase on every state change so durations are exact.
      if (nstate != state || nstate == IDLE || nstate == TRIG) begin
        pre  <= '0;
        ucnt <= '0;
      end else if (us_tick) begin
        pre  <= '0;
        ucnt <= ucnt + 16'd1;
      end else begin
        pre  <= pre + 1'b1;
      end

      // Out-of-range or absent targets collapse to the no-echo width here, so
      // ECHO only ever sees a width in 1..NO_ECHO_US.
      if (state == TRIG && nstate == BURST)
        w_us <= (!target_valid || echo_us == 16'd0 || echo_us > NO_ECHO) ?
                NO_ECHO : echo_us;
    end
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    runt   = 1'b0;
    case (state)
      IDLE:    if (trig_rise) nstate = TRIG;
      TRIG:    if (!trig_s) begin
                 if (wcnt >= MIN_W) nstate = BURST;
                 else begin
                   nstate = IDLE;
                   runt   = 1'b1;
                 end
               end
      BURST:   if (us_tick && ucnt == BURST_LAST)   nstate = ECHO;
      ECHO:    if (us_tick && ucnt == w_us - 16'd1) nstate = HOLDOFF;
      HOLDOFF: if (us_tick && ucnt == HOLD_LAST)    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Output decode from the next state; registered above so echo/busy change
  // on the same edge as the state.
  always_comb begin
    echo_d = (nstate == ECHO);
    busy_d = (nstate == BURST) || (nstate == ECHO) || (nstate == HOLDOFF);
  end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Bench for hcsr04_emulator with scaled-down timing. The reference model
// predicts, per accepted trigger, the clock intervals in which busy and echo
// are high (and the cycle of trig_err for a rejected runt); a negedge process
// compares all three outputs against that every cycle.
module tb_hcsr04_emulator;
  localparam int CPU  = 4;
  localparam int MINU = 3;
  localparam int BD   = 5;
  localparam int NOE  = 60;
  localparam int HO   = 10;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
  localparam int MINCYC = MINU * CPU;
`else
  localparam int MINCYC = 1;
`endif

  logic        clk = 1'b0, reset = 1'b1, trig = 1'b0, target_valid = 1'b0;
  logic [15:0] echo_us = '0;
  logic        echo, busy, trig_err;

  int cyc = 0, total = 0, bad = 0;
  int echo_s = 0, echo_e = 0, busy_s = 0, busy_e = 0, err_at = -100;
  int rise_c = 0, fall_c = 0, brise_c = 0, bfall_c = 0, errcnt = 0, busycnt = 0;
  logic pe = 1'b0, pb = 1'b0;
  logic ee, eb, er;

  hcsr04_emulator #(
    .CLK_PER_US(CPU), .MIN_TRIG_US(MINU), .BURST_DELAY_US(BD),
    .NO_ECHO_US(NOE), .HOLDOFF_US(HO)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .echo_us(echo_us),
    .target_valid(target_valid), .echo(echo), .busy(busy), .trig_err(trig_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare, sampled half a clock after each active edge.
  always @(negedge clk) begin
    ee = !reset && cyc >= echo_s && cyc < echo_e;
    eb = !reset && cyc >= busy_s && cyc < busy_e;
    er = !reset && cyc == err_at;
    check("echo", echo, ee);
    check("busy", busy, eb);
    check("trig_err", trig_err, er);
    if (echo && !pe) rise_c = cyc;
    if (!echo && pe) fall_c = cyc;
    if (busy && !pb) brise_c = cyc;
    if (!busy && pb) bfall_c = cyc;
    if (trig_err === 1'b1) errcnt++;
    if (busy === 1'b1) busycnt++;
    pe = echo;
    pb = busy;
  end

  // e0 = index of the first edge that samples trig low.
  task automatic pulse(input int t, output int e0);
    @(posedge clk); #1 trig = 1'b1;
    repeat (t) @(posedge clk);
    #1 trig = 1'b0;
    e0 = cyc + 1;
  endtask

  task automatic measure(input int t, input logic [15:0] eu, input bit tv, output int e0);
    int w;
    echo_us = eu;
    target_valid = tv;
    pulse(t, e0);
    if (t >= MINCYC) begin
      w = (!tv || eu == 16'd0 || int'(eu) > NOE) ? NOE : int'(eu);
      busy_s = e0 + 2;
      echo_s = busy_s + BD * CPU;
      echo_e = echo_s + w * CPU;
      busy_e = echo_e + HO * CPU;
    end else if (MINCYC > 1) begin
      err_at = e0 + 2;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int lim);
    while (cyc < lim) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int gap);
    wait_until(((busy_e > err_at) ? busy_e : err_at) + 2 + gap);
  endtask

  int e0, dummy, t, w;
  logic [15:0] eu;
  bit tv;
  int nt_eu[4] = '{10, 0, 70, 61};
  bit nt_tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #2;
    check("reset echo", echo, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset trig_err", trig_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Nominal: 10 us target, latched before echo_us is changed mid-BURST.
    measure(20, 16'd10, 1'b1, e0);
    echo_us = 16'd30;
    wait_idle(3);
    check("nominal busy rise", brise_c - e0, 2);
    check("nominal echo rise", rise_c - e0, 22);
    check("nominal echo width", fall_c - rise_c, 40);
    check("nominal holdoff", bfall_c - fall_c, 40);

    // No target / zero / out of range all give the full no-echo width.
    foreach (nt_eu[i]) begin
      measure(20, 16'(nt_eu[i]), nt_tv[i], e0);
      wait_idle(2);
      check("no-echo width", fall_c - rise_c, 240);
    end
    measure(20, 16'd60, 1'b1, e0);
    wait_idle(2);
    check("max width", fall_c - rise_c, 240);
    measure(20, 16'd1, 1'b1, e0);
    wait_idle(2);
    check("min width", fall_c - rise_c, 4);

    // Retrigger during ECHO is ignored.
    measure(20, 16'd10, 1'b1, e0);
    wait_until(echo_s + 5);
    pulse(3, dummy);
    wait_idle(2);
    check("retrig width", fall_c - rise_c, 40);

    // Runt pulse.
    errcnt = 0;
    busycnt = 0;
    measure(5, 16'd10, 1'b1, e0);
    wait_idle(4);
`ifdef HCSR04_EMU_TRIG_CHECK_EN
    check("runt trig_err cycles", errcnt, 1);
    check("runt busy cycles", busycnt, 0);
`else
    check("short trig accepted width", fall_c - rise_c, 40);
`endif

    // Randomized measurements with optional retrigger and input churn.
    for (int n = 0; n < 40; n++) begin
      t  = $urandom_range(1, 20);
      eu = 16'($urandom_range(0, 70));
      tv = ($urandom_range(0, 3) != 0);
      measure(t, eu, tv, e0);
      echo_us = 16'($urandom_range(0, 70));
      target_valid = $urandom_range(0, 1);
      if (t >= MINCYC && $urandom_range(0, 1) == 1) begin
        wait_until(busy_s + $urandom_range(4, busy_e - busy_s - 20));
        pulse($urandom_range(1, 4), dummy);
      end
      wait_idle($urandom_range(0, 5));
      if (t >= MINCYC) begin
        w = (!tv || eu == 16'd0 || int'(eu) > NOE) ? NOE : int'(eu);
        check("random echo width", fall_c - rise_c, w * CPU);
      end
    end

    // Reset in the middle of ECHO, then a clean measurement.
    measure(20, 16'd10, 1'b1, e0);
    wait_until(echo_s + 20);
    #2 reset = 1'b1;
    echo_s = 0; echo_e = 0; busy_s = 0; busy_e = 0;
    #1;
    check("reset mid echo", echo, 1'b0);
    check("reset mid busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    measure(20, 16'd10, 1'b1, e0);
    wait_idle(2);
    check("post-reset echo rise", rise_c - e0, 22);
    check("post-reset echo width", fall_c - rise_c, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
